// File: rtl/nes_joypad_pkg.sv
// Shared constants and helpers for the NES joypad bridge: button bit positions,
// shift register width, Four Score signatures and the per-port load word builder.
package nes_joypad_pkg;

    typedef enum logic [2:0] {
        BTN_A      = 3'd0,
        BTN_B      = 3'd1,
        BTN_SELECT = 3'd2,
        BTN_START  = 3'd3,
        BTN_UP     = 3'd4,
        BTN_DOWN   = 3'd5,
        BTN_LEFT   = 3'd6,
        BTN_RIGHT  = 3'd7
    } btnIdx_e;

    localparam int SR_W = 24;

    // Signatures are stored so that LSB-first shifting yields 0001_0000 / 0010_0000.
    localparam logic [7:0] FS_SIG_P1 = 8'h08;
    localparam logic [7:0] FS_SIG_P2 = 8'h04;

    typedef enum logic {
        MODE_STANDARD   = 1'b0,
        MODE_FOUR_SCORE = 1'b1
    } readMode_e;

    function automatic logic [SR_W-1:0] buildLoadWord(
        input readMode_e  mode,
        input logic [7:0] sig,
        input logic [7:0] firstPad,
        input logic [7:0] secondPad
    );
        if (mode == MODE_FOUR_SCORE) begin
            return {sig, secondPad, firstPad};
        end
        return {16'hFFFF, firstPad};
    endfunction

endpackage

// File: rtl/nes_joypad_shifter.sv
// One NES controller port: reloads while latched, shifts on each rising read
// clock, and backfills ones so an exhausted port reads 1 forever.
module nes_joypad_shifter
    import nes_joypad_pkg::*;
#(
    parameter bit ACTIVE_LOW_OUT = 1'b0
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [SR_W-1:0] load_word_i,
    input  logic            latch_i,
    input  logic            jp_clk_i,
    output logic            data_o
);

    logic [SR_W-1:0] sr_q;
    logic [SR_W-1:0] sr_d;
    logic            jpClk_q;
    logic            clkRise;

    assign clkRise = jp_clk_i & ~jpClk_q;

    // Latch takes priority, so an edge coinciding with the strobe is swallowed.
    always_comb begin
        sr_d = sr_q;
        if (latch_i) begin
            sr_d = load_word_i;
        end else if (clkRise) begin
            sr_d = {1'b1, sr_q[SR_W-1:1]};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sr_q    <= '1;
            jpClk_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            jpClk_q <= jp_clk_i;
        end
    end

    assign data_o = sr_q[0] ^ ACTIVE_LOW_OUT;

endmodule

// File: rtl/nes_joypad_bridge.sv
// Emulates up to four NES pads (with Four Score multiplexing and A/B turbo)
// behind the two rp2a03 joypad ports.
module nes_joypad_bridge
    import nes_joypad_pkg::*;
#(
    parameter int NUM_PADS       = 2,
    parameter int TURBO_DIV      = 3333333,
    parameter bit ACTIVE_LOW_OUT = 1'b0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [NUM_PADS*8-1:0] buttons_in,
    input  logic [NUM_PADS*2-1:0] turbo_en_in,
    input  logic                  four_score_in,
    input  logic                  jp_latch_in,
    input  logic [1:0]            jp_clk_in,
    output logic [1:0]            jp_data_out
);

    localparam int CNT_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TURBO_DIV - 1);

    logic [NUM_PADS*8-1:0] btnMeta_q;
    logic [NUM_PADS*8-1:0] btnSync_q;
    logic [NUM_PADS*2-1:0] turboMeta_q;
    logic [NUM_PADS*2-1:0] turboSync_q;
    logic                  fsMeta_q;
    logic                  fsSync_q;

    logic [CNT_W-1:0]      turboCnt_q;
    logic [CNT_W-1:0]      turboCnt_d;
    logic                  turboPhase_q;
    logic                  turboPhase_d;

    logic [7:0]            padEff [4];
    readMode_e             mode;
    logic [SR_W-1:0]       loadWord [2];

    // Button, turbo and mode inputs come from an unrelated source.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            btnMeta_q   <= '0;
            btnSync_q   <= '0;
            turboMeta_q <= '0;
            turboSync_q <= '0;
            fsMeta_q    <= 1'b0;
            fsSync_q    <= 1'b0;
        end else begin
            btnMeta_q   <= buttons_in;
            btnSync_q   <= btnMeta_q;
            turboMeta_q <= turbo_en_in;
            turboSync_q <= turboMeta_q;
            fsMeta_q    <= four_score_in;
            fsSync_q    <= fsMeta_q;
        end
    end

    always_comb begin
        turboCnt_d   = turboCnt_q + 1'b1;
        turboPhase_d = turboPhase_q;
        if (turboCnt_q == CNT_MAX) begin
            turboCnt_d   = '0;
            turboPhase_d = ~turboPhase_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            turboCnt_q   <= '0;
            turboPhase_q <= 1'b0;
        end else begin
            turboCnt_q   <= turboCnt_d;
            turboPhase_q <= turboPhase_d;
        end
    end

    // Turbo reports A/B released during phase 0; absent pads read as nothing pressed.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            padEff[n] = 8'h00;
        end
        for (int n = 0; n < NUM_PADS; n++) begin
            padEff[n] = btnSync_q[8*n +: 8];
            padEff[n][BTN_A] = padEff[n][BTN_A] & ~(turboSync_q[2*n] & ~turboPhase_q);
            padEff[n][BTN_B] = padEff[n][BTN_B] & ~(turboSync_q[2*n+1] & ~turboPhase_q);
        end
    end

    assign mode = ((NUM_PADS == 4) && fsSync_q) ? MODE_FOUR_SCORE : MODE_STANDARD;

    assign loadWord[0] = buildLoadWord(mode, FS_SIG_P1, padEff[0], padEff[2]);
    assign loadWord[1] = buildLoadWord(mode, FS_SIG_P2, padEff[1], padEff[3]);

    for (genvar p = 0; p < 2; p++) begin : g_port
        nes_joypad_shifter #(
            .ACTIVE_LOW_OUT(ACTIVE_LOW_OUT)
        ) u_shifter (
            .clk_in     (clk_in),
            .rst_in     (rst_in),
            .load_word_i(loadWord[p]),
            .latch_i    (jp_latch_in),
            .jp_clk_i   (jp_clk_in[p]),
            .data_o     (jp_data_out[p])
        );
    end

endmodule

// File: tb/tb_nes_joypad_bridge.sv
// Directed bench for the joypad bridge: table-driven serial reads plus hand
// sequences for latch priority, synchroniser delay, reset and turbo timing.
module tb_nes_joypad_bridge;

    localparam int NUM_PADS  = 4;
    localparam int TURBO_DIV = 4;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] buttons_in;
    logic [7:0]  turbo_en_in;
    logic        four_score_in;
    logic        jp_latch_in;
    logic [1:0]  jp_clk_in;
    logic [1:0]  jp_data_out;

    nes_joypad_bridge #(
        .NUM_PADS      (NUM_PADS),
        .TURBO_DIV     (TURBO_DIV),
        .ACTIVE_LOW_OUT(1'b0)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .buttons_in   (buttons_in),
        .turbo_en_in  (turbo_en_in),
        .four_score_in(four_score_in),
        .jp_latch_in  (jp_latch_in),
        .jp_clk_in    (jp_clk_in),
        .jp_data_out  (jp_data_out)
    );

    always #5 clk_in = ~clk_in;

    // exp bit k-1 holds the value expected on read k (read 1 is before any clock)
    typedef struct {
        logic [31:0] buttons;
        logic        fourScore;
        logic [1:0]  clkMask;
        int          reads;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [6];
    int   assertCount = 0;
    int   failCount   = 0;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic latchPulse();
        jp_latch_in = 1'b1;
        @(negedge clk_in);
        jp_latch_in = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        buttons_in    = v.buttons;
        four_score_in = v.fourScore;
        turbo_en_in   = 8'h00;
        jp_clk_in     = 2'b00;
        repeat (3) @(negedge clk_in);
        latchPulse();
        for (int k = 1; k <= v.reads; k++) begin
            if (k > 1) begin
                jp_clk_in = v.clkMask;
                @(negedge clk_in);
            end
            checkOutput($sformatf("vec%0d port1 read%0d", idx, k), 8'(jp_data_out[0]), 8'(v.exp1[k-1]));
            checkOutput($sformatf("vec%0d port2 read%0d", idx, k), 8'(jp_data_out[1]), 8'(v.exp2[k-1]));
            if (k > 1) begin
                jp_clk_in = 2'b00;
                @(negedge clk_in);
            end
        end
    endtask

    task automatic shiftPort1();
        jp_clk_in[0] = 1'b1;
        @(negedge clk_in);
        jp_clk_in[0] = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0081, 1'b0, 2'b01, 10, 32'hFFFF_FF81, 32'h0000_0000};
        vecs[1] = '{32'h0000_C35A, 1'b0, 2'b11, 12, 32'hFFFF_FF5A, 32'hFFFF_FFC3};
        vecs[2] = '{32'h3CA5_FF00, 1'b0, 2'b11, 10, 32'hFFFF_FF00, 32'hFFFF_FFFF};
        vecs[3] = '{32'h0804_0201, 1'b1, 2'b11, 25, 32'hFF08_0401, 32'hFF04_0802};
        vecs[4] = '{32'h3CA5_FF00, 1'b1, 2'b11, 26, 32'hFF08_A500, 32'hFF04_3CFF};
        vecs[5] = '{32'h0804_0201, 1'b1, 2'b10, 25, 32'hFFFF_FFFF, 32'hFF04_0802};

        rst_in        = 1'b1;
        buttons_in    = 32'h0;
        turbo_en_in   = 8'h00;
        four_score_in = 1'b0;
        jp_latch_in   = 1'b0;
        jp_clk_in     = 2'b00;
        repeat (3) @(negedge clk_in);
        checkOutput("reset state", 8'(jp_data_out), 8'h03);
        rst_in = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], i);
        end

        // latch held while port1 clock toggles: no shifting until latch drops
        four_score_in = 1'b0;
        buttons_in    = 32'h0000_0002;
        repeat (3) @(negedge clk_in);
        jp_latch_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            jp_clk_in[0] = ~jp_clk_in[0];
            @(negedge clk_in);
            checkOutput($sformatf("latch held toggle%0d", i), 8'(jp_data_out[0]), 8'h00);
        end
        jp_latch_in = 1'b0;
        @(negedge clk_in);
        checkOutput("after latch falls", 8'(jp_data_out[0]), 8'h00);
        shiftPort1();
        checkOutput("first edge after latch", 8'(jp_data_out[0]), 8'h01);
        @(negedge clk_in);

        // synchroniser delay: change one cycle before latch loads the old value
        buttons_in = 32'h0000_0001;
        repeat (4) @(negedge clk_in);
        buttons_in = 32'h0000_0000;
        @(negedge clk_in);
        latchPulse();
        checkOutput("sync old value", 8'(jp_data_out[0]), 8'h01);
        buttons_in = 32'h0000_0001;
        repeat (3) @(negedge clk_in);
        latchPulse();
        checkOutput("sync new value", 8'(jp_data_out[0]), 8'h01);
        buttons_in = 32'h0000_0000;
        repeat (3) @(negedge clk_in);
        latchPulse();
        checkOutput("sync cleared value", 8'(jp_data_out[0]), 8'h00);

        // reset in the middle of a read
        buttons_in = 32'h0000_0008;
        repeat (3) @(negedge clk_in);
        latchPulse();
        checkOutput("midread read1", 8'(jp_data_out), 8'h00);
        for (int k = 1; k <= 3; k++) begin
            shiftPort1();
            @(negedge clk_in);
            checkOutput($sformatf("midread read%0d", k + 1), 8'(jp_data_out), (k == 3) ? 8'h01 : 8'h00);
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        checkOutput("reset mid-read", 8'(jp_data_out), 8'h03);
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        latchPulse();
        checkOutput("relatch after reset", 8'(jp_data_out), 8'h00);

        // read clocks held high across reset
        buttons_in = 32'h0000_0002;
        jp_clk_in  = 2'b11;
        rst_in     = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checkOutput("clk high after reset", 8'(jp_data_out), 8'h03);
        latchPulse();
        checkOutput("latched with clk high", 8'(jp_data_out), 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            checkOutput($sformatf("no spurious edge%0d", i), 8'(jp_data_out), 8'h00);
        end
        jp_clk_in = 2'b10;
        @(negedge clk_in);
        jp_clk_in = 2'b11;
        @(negedge clk_in);
        checkOutput("single shift after reset", 8'(jp_data_out), 8'h01);
        jp_clk_in = 2'b00;
        @(negedge clk_in);

        // turbo: reset aligns the counter, so phase after edge k is (k/TURBO_DIV)%2
        buttons_in  = 32'h0000_0103;
        turbo_en_in = 8'h01;
        rst_in      = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        jp_latch_in = 1'b1;
        for (int k = 3; k <= 18; k++) begin
            @(negedge clk_in);
            checkOutput($sformatf("turbo A cycle%0d", k), 8'(jp_data_out[0]), 8'(((k - 1) / TURBO_DIV) % 2));
            checkOutput($sformatf("no turbo pad1 A cycle%0d", k), 8'(jp_data_out[1]), 8'h01);
        end
        jp_latch_in  = 1'b0;
        jp_clk_in[0] = 1'b1;
        @(negedge clk_in);
        checkOutput("turbo B unmasked", 8'(jp_data_out[0]), 8'h01);
        jp_clk_in   = 2'b00;
        turbo_en_in = 8'h00;
        @(negedge clk_in);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
